// File: rtl/video_sync_gen.sv
// Parametrised raster timing generator with frame-boundary mode switching and the PCW line timer.
// Define VIDEO_SYNC_TIMER_LATCH_EN to make o_timer an acknowledged level request with a missed-tick count.
module video_sync_gen #(
    parameter int HW          = 11,
    parameter int VW          = 10,
    parameter int H_FP        = 96,
    parameter int H_SYNC      = 64,
    parameter int H_BP        = 144,
    parameter int H_ACTIVE    = 720,
    parameter int PREFETCH    = 8,
    parameter int V0_FP       = 26,
    parameter int V0_SYNC     = 4,
    parameter int V0_BP       = 26,
    parameter int V0_ACTIVE   = 256,
    parameter int V1_FP       = 30,
    parameter int V1_SYNC     = 4,
    parameter int V1_BP       = 26,
    parameter int V1_ACTIVE   = 200,
    parameter int TIMER_LINES = 52,
    parameter int TIMER_W     = 6
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pix_stb,
    input  logic          i_mode,
`ifdef VIDEO_SYNC_TIMER_LATCH_EN
    input  logic          i_timer_ack,
    output logic [3:0]    o_timer_missed,
`endif
    output logic          o_mode,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_hblank,
    output logic          o_vblank,
    output logic          o_active,
    output logic          o_prefetch,
    output logic          o_linestart,
    output logic          o_screenstart,
    output logic          o_animate,
    output logic [HW-1:0] o_x,
    output logic [8:0]    o_y,
    output logic          o_timer
);

    localparam int HS_STA = H_FP;
    localparam int HS_END = HS_STA + H_SYNC;
    localparam int HA_STA = HS_END + H_BP;
    localparam int LINE   = HA_STA + H_ACTIVE;

    localparam int V0_VS_STA = V0_ACTIVE + V0_FP;
    localparam int V0_VS_END = V0_VS_STA + V0_SYNC;
    localparam int V0_SCREEN = V0_VS_END + V0_BP;
    localparam int V1_VS_STA = V1_ACTIVE + V1_FP;
    localparam int V1_VS_END = V1_VS_STA + V1_SYNC;
    localparam int V1_SCREEN = V1_VS_END + V1_BP;

    localparam logic [HW-1:0]      HS_STA_C = HW'(HS_STA);
    localparam logic [HW-1:0]      HS_END_C = HW'(HS_END);
    localparam logic [HW-1:0]      HA_STA_C = HW'(HA_STA);
    localparam logic [HW-1:0]      PF_STA_C = HW'(HA_STA - PREFETCH);
    localparam logic [HW-1:0]      H_LAST   = HW'(LINE - 1);
    localparam logic [HW-1:0]      H_ONE    = HW'(1);
    localparam logic [VW-1:0]      V_ONE    = VW'(1);
    localparam logic [TIMER_W-1:0] T_RELOAD = TIMER_W'(TIMER_LINES - 1);
    localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);

    logic [HW-1:0]      h;
    logic [VW-1:0]      v;
    logic               mode;
    logic [TIMER_W-1:0] tcount;
    logic               timer;

    logic [VW-1:0] va, vs_sta, vs_end, v_last, tsync;
    logic [8:0]    y_max;
    logic          eol, tick, hblank, vblank;

    always_comb begin
        va     = mode ? VW'(V1_ACTIVE)     : VW'(V0_ACTIVE);
        vs_sta = mode ? VW'(V1_VS_STA)     : VW'(V0_VS_STA);
        vs_end = mode ? VW'(V1_VS_END)     : VW'(V0_VS_END);
        v_last = mode ? VW'(V1_SCREEN - 1) : VW'(V0_SCREEN - 1);
        tsync  = mode ? VW'(V1_VS_END + 2) : VW'(V0_VS_END + 2);
        y_max  = mode ? 9'(V1_ACTIVE - 1)  : 9'(V0_ACTIVE - 1);
    end

    assign eol  = (h == H_LAST);
    assign tick = i_pix_stb & eol & ((tcount == '0) | (v == tsync));

    // Mode is only sampled on the frame-wrap strobe, so a frame's length is fixed once it starts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h      <= '0;
            v      <= '0;
            mode   <= 1'b0;
            tcount <= T_RELOAD;
        end else if (i_pix_stb) begin
            if (eol) begin
                h      <= '0;
                tcount <= tick ? T_RELOAD : tcount - T_ONE;
                if (v == v_last) begin
                    v    <= '0;
                    mode <= i_mode;
                end else begin
                    v <= v + V_ONE;
                end
            end else begin
                h <= h + H_ONE;
            end
        end
    end

`ifdef VIDEO_SYNC_TIMER_LATCH_EN
    logic [3:0] missed;

    // An ack coinciding with a tick leaves the request set and restarts the missed count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            timer  <= 1'b0;
            missed <= '0;
        end else if (i_timer_ack) begin
            timer  <= tick;
            missed <= '0;
        end else if (tick) begin
            timer <= 1'b1;
            if (timer && missed != 4'hF)
                missed <= missed + 4'd1;
        end
    end

    assign o_timer_missed = missed;
`else
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            timer <= 1'b0;
        else
            timer <= tick;
    end
`endif

    assign hblank        = (h < HA_STA_C);
    assign vblank        = (v >= va);
    assign o_timer       = timer;
    assign o_mode        = mode;
    assign o_hs          = ~((h >= HS_STA_C) & (h < HS_END_C));
    assign o_vs          = ~((v >= vs_sta) & (v < vs_end));
    assign o_hblank      = hblank;
    assign o_vblank      = vblank;
    assign o_active      = ~hblank & ~vblank;
    assign o_prefetch    = (h >= PF_STA_C) & ~vblank;
    assign o_x           = hblank ? '0 : h - HA_STA_C;
    assign o_y           = vblank ? y_max : 9'(v);
    assign o_linestart   = (h == '0);
    assign o_screenstart = (h == '0) & (v == '0);
    assign o_animate     = eol & (v == va - V_ONE);

endmodule

// File: doc/video_sync_gen.md
Name: video_sync_gen

Overview:
- Parametrised raster timing generator for the PCW video path. Produces sync, blanking, active, prefetch and position outputs, plus the 300 Hz-class PCW timer interrupt.
- Supersedes the fixed PAL/NTSC generator. All horizontal and vertical timings are parameters, two vertical mode sets exist, and mode changes are applied only at frame boundaries.
- Sits between the pixel-clock strobe source and the video fetch, roller-RAM and interrupt logic.

Parameters:
- HW, 11: horizontal counter and o_x width.
- VW, 10: vertical counter width. o_y is 9 bits.
- H_FP, 96: horizontal front porch, in pixels.
- H_SYNC, 64: horizontal sync length, in pixels.
- H_BP, 144: horizontal back porch, in pixels.
- H_ACTIVE, 720: active pixels per line.
- PREFETCH, 8: number of pixels o_prefetch leads o_active.
- V0_FP, 26 / V0_SYNC, 4 / V0_BP, 26 / V0_ACTIVE, 256: mode 0 (PAL) vertical timing, in lines.
- V1_FP, 30 / V1_SYNC, 4 / V1_BP, 26 / V1_ACTIVE, 200: mode 1 (NTSC) vertical timing, in lines.
- TIMER_LINES, 52: lines per timer tick.
- TIMER_W, 6: timer counter width. Must satisfy TIMER_LINES ≤ 2^TIMER_W.

Ports:
- i_clk  in  1  base clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_pix_stb  in  1  pixel strobe. All counting advances only on cycles where this is 1.
- i_mode  in  1  requested vertical mode: 0 = set V0, 1 = set V1.
- o_mode  out  1  vertical mode currently in effect.
- o_hs, o_vs  out  1  horizontal and vertical sync, active low.
- o_hblank, o_vblank, o_active, o_prefetch  out  1  region flags.
- o_linestart, o_screenstart, o_animate  out  1  event flags.
- o_x  out  HW  active pixel x position.
- o_y  out  9  active line y position.
- o_timer  out  1  timer interrupt pulse.

Behaviour:
- Derived constants:
  - HS_STA = H_FP; HS_END = HS_STA + H_SYNC; HA_STA = HS_END + H_BP; LINE = HA_STA + H_ACTIVE.
  - For the active mode m: VA = Vm_ACTIVE; VS_STA = VA + Vm_FP; VS_END = VS_STA + Vm_SYNC; SCREEN = VS_END + Vm_BP; TSYNC = VS_END + 2.
- Counters:
  - h runs 0..LINE-1. v runs 0..SCREEN-1.
  - On each strobe: h increments. When h = LINE-1 the strobe instead sets h to 0 and advances v; v wraps to 0 after SCREEN-1.
- Reset: asynchronous.
  - h = 0, v = 0, mode register = 0, timer count = TIMER_LINES-1, o_timer = 0.
  - Therefore o_linestart = 1 and o_screenstart = 1 immediately after reset.
- Mode latch:
  - i_mode is sampled only on the strobe where h = LINE-1 and v = SCREEN-1 (the frame wrap).
  - The new mode governs the frame that begins at (0,0). A change mid-frame never alters the current frame length.
- Combinational decode from h, v and the mode register (zero latency relative to the counters):
  - o_hs = 0 iff HS_STA ≤ h < HS_END. o_vs = 0 iff VS_STA ≤ v < VS_END.
  - o_hblank = (h < HA_STA). o_vblank = (v ≥ VA). o_active = ~o_hblank & ~o_vblank.
  - o_prefetch = (h ≥ HA_STA-PREFETCH) & ~o_vblank.
  - o_x = 0 when h < HA_STA, otherwise h-HA_STA.
  - o_y = v when v < VA, otherwise VA-1 (clamped).
  - o_linestart = (h = 0). o_screenstart = (h = 0 & v = 0). o_animate = (h = LINE-1 & v = VA-1).
- Timer, evaluated on each end-of-line strobe (h = LINE-1):
  - If count = 0 or v = TSYNC: count reloads to TIMER_LINES-1 and a tick fires.
  - Otherwise count decrements.
  - A tick drives o_timer = 1 for exactly one i_clk cycle, the cycle after that strobe. o_timer is 0 at all other times.
- With i_pix_stb held at 0, all state freezes and no tick is generated.
- Simultaneous count = 0 and v = TSYNC produce a single tick.

Optional Feature:
- Macro: VIDEO_SYNC_TIMER_LATCH_EN.
- When defined, two ports are added: i_timer_ack (in, 1) and o_timer_missed (out, 4).
  - o_timer becomes a level request: set by a tick, cleared by i_timer_ack.
  - Each tick arriving while the request is already set increments o_timer_missed, saturating at 15.
  - i_timer_ack clears both o_timer and o_timer_missed.
  - Ack and tick in the same cycle: o_timer stays 1 and o_timer_missed = 0.
  - Reset clears both.
- When undefined: the one-cycle pulse behaviour above applies and neither port exists.

Test Plan:
- Reset, i_mode = 0, strobe every cycle:
  - Line = 1024 strobes and frame = 312 lines.
  - o_hs low for h 96..159.
  - o_x = 0 at h 304 and 719 at h 1023.
  - o_prefetch rises at h 296.
  - o_vs low for v 282..285; o_animate at v 255, h 1023.
- Set i_mode = 1 at v = 100:
  - The current frame still runs 312 lines.
  - The next frame runs 260 lines, o_vs is low for v 230..233, and o_y clamps at 199.
  - o_mode changes exactly at the (0,0) wrap.
- Timer in mode 0 from reset: ticks at the end of lines 51, 103, 155, 207 and 259, a forced tick at line 288, then the next tick at line 28 of the following frame. Each o_timer pulse is exactly 1 i_clk wide.
- i_pix_stb = 1 every 4th cycle, then held at 0 for 100 cycles: counters and outputs freeze, no o_timer, and counting resumes from the same h and v.
- Assert i_rst asynchronously mid-line at h = 500, v = 120: all outputs reach their reset values without waiting for a clock edge, and o_mode = 0.
- TIMER_LATCH_EN, no ack for 3 ticks: o_timer = 1 and o_timer_missed = 2. Ack coinciding with a tick: o_timer = 1 and missed = 0.
